// File: rtl/vma412_pkg.sv
// Shared types and the ILI9341 power-up list for the VMA412 8080-style panel sequencer.
package vma412_pkg;

   typedef enum logic [2:0] {
      ST_RST_LO,
      ST_RST_WAIT,
      ST_INIT,
      ST_INIT_DLY,
      ST_READY
   } seq_state_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_LOW,
      WR_HIGH
   } wr_state_t;

   typedef struct packed {
      logic       dly;
      logic       dc;
      logic [7:0] data;
   } init_entry_t;

   localparam int INIT_LEN = 7;
   localparam int IDX_W    = $clog2(INIT_LEN);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // dly=1 entries need the controller's settle time before the next byte.
   function automatic init_entry_t init_rom(input logic [IDX_W-1:0] idx);
      case (idx)
         IDX_W'(0): return '{dly: 1'b1, dc: 1'b0, data: 8'h01};  // SWRESET
         IDX_W'(1): return '{dly: 1'b1, dc: 1'b0, data: 8'h11};  // SLPOUT
         IDX_W'(2): return '{dly: 1'b0, dc: 1'b0, data: 8'h3A};  // COLMOD
         IDX_W'(3): return '{dly: 1'b0, dc: 1'b1, data: 8'h55};  // 16 bpp
         IDX_W'(4): return '{dly: 1'b0, dc: 1'b0, data: 8'h36};  // MADCTL
         IDX_W'(5): return '{dly: 1'b0, dc: 1'b1, data: 8'h48};
         default:   return '{dly: 1'b0, dc: 1'b0, data: 8'h29};  // DISPON
      endcase
   endfunction

endpackage

// File: rtl/vma412_bus_writer.sv
// One-byte 8080 write strobe: wrx low for WR_LOW_CYC, high for WR_HIGH_CYC, bus held stable.
module vma412_bus_writer
   import vma412_pkg::*;
#(
   parameter int unsigned WR_LOW_CYC  = 2,
   parameter int unsigned WR_HIGH_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dc,
   input  logic [7:0] data,
   output logic       avail,
   output logic       done,
   output logic       idle,
   output logic       wrx,
   output logic       dcx,
   output logic [7:0] lcd_d
);

   // Handshake: start is consumed on any cycle avail is high (idle, or the
   // final wrx-high cycle so writes chain with no dead cycle); done marks that
   // final cycle of the current write.
   localparam int CW = $clog2(max2(WR_LOW_CYC, WR_HIGH_CYC) + 1);
   localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW_CYC - 1);
   localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH_CYC - 1);

   wr_state_t     state;
   logic [CW-1:0] cnt;
   logic          last_high;

   assign last_high = (state == WR_HIGH) && (cnt == HIGH_LAST);
   assign avail     = (state == WR_IDLE) || last_high;
   assign done      = last_high;
   assign idle      = (state == WR_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WR_IDLE;
         cnt   <= '0;
         wrx   <= 1'b1;
         dcx   <= 1'b1;
         lcd_d <= 8'h00;
      end else begin
         case (state)
            WR_IDLE: begin
               if (start) begin
                  state <= WR_LOW;
                  cnt   <= '0;
                  wrx   <= 1'b0;
                  dcx   <= dc;
                  lcd_d <= data;
               end
            end
            WR_LOW: begin
               if (cnt == LOW_LAST) begin
                  state <= WR_HIGH;
                  cnt   <= '0;
                  wrx   <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WR_HIGH: begin
               if (cnt == HIGH_LAST) begin
                  cnt <= '0;
                  if (start) begin
                     state <= WR_LOW;
                     wrx   <= 1'b0;
                     dcx   <= dc;
                     lcd_d <= data;
                  end else begin
                     state <= WR_IDLE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= WR_IDLE;
               cnt   <= '0;
               wrx   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/vma412_sequencer.sv
// VMA412 (ILI9341) panel sequencer: hardware reset, init list playback, then host byte pass-through.
module vma412_sequencer
   import vma412_pkg::*;
#(
   parameter int unsigned RST_LOW_CYC  = 500,
   parameter int unsigned RST_WAIT_CYC = 6_000_000,
   parameter int unsigned DLY_CYC      = 6_000_000,
   parameter int unsigned WR_LOW_CYC   = 2,
   parameter int unsigned WR_HIGH_CYC  = 2
) (
   input  logic       CLOCK_50,
   input  logic       KEY0,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_dc,
   input  logic [7:0] cmd_data,
   output logic       init_done,
   output logic       busy,
   output logic       csx,
   output logic       resx,
   output logic       dcx,
   output logic       wrx,
   output logic       rdx,
   output logic [7:0] lcd_d
);

   localparam int unsigned CNT_MAX = max2(max2(RST_LOW_CYC, RST_WAIT_CYC), DLY_CYC);
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0]    LO_LAST   = CW'(RST_LOW_CYC - 1);
   localparam logic [CW-1:0]    WAIT_LAST = CW'(RST_WAIT_CYC - 1);
   localparam logic [CW-1:0]    DLY_LAST  = CW'(DLY_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(INIT_LEN - 1);

   seq_state_t       state;
   logic [CW-1:0]    cnt;
   logic [IDX_W-1:0] idx;
   logic             issued;
   init_entry_t      entry;

   logic       wr_start, wr_dc, wr_avail, wr_done, wr_idle;
   logic [7:0] wr_data;

   assign entry     = init_rom(idx);
   assign cmd_ready = (state == ST_READY) && wr_avail;
   assign busy      = (state != ST_READY) || !wr_idle;
   assign rdx       = 1'b1;

   // The writer is shared: INIT feeds it from the ROM, READY from the host.
   always_comb begin
      wr_start = 1'b0;
      wr_dc    = cmd_dc;
      wr_data  = cmd_data;
      case (state)
         ST_INIT: begin
            wr_start = !issued && wr_avail;
            wr_dc    = entry.dc;
            wr_data  = entry.data;
         end
         ST_READY: wr_start = cmd_valid && wr_avail;
         default:  wr_start = 1'b0;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         state     <= ST_RST_LO;
         cnt       <= '0;
         idx       <= '0;
         issued    <= 1'b0;
         init_done <= 1'b0;
         csx       <= 1'b1;
         resx      <= 1'b0;
      end else begin
         case (state)
            ST_RST_LO: begin
               if (cnt == LO_LAST) begin
                  state <= ST_RST_WAIT;
                  cnt   <= '0;
                  resx  <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_RST_WAIT: begin
               if (cnt == WAIT_LAST) begin
                  state  <= ST_INIT;
                  cnt    <= '0;
                  idx    <= '0;
                  issued <= 1'b0;
                  csx    <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_INIT: begin
               if (wr_start) begin
                  issued <= 1'b1;
               end else if (issued && wr_done) begin
                  issued <= 1'b0;
                  if (entry.dly) begin
                     state <= ST_INIT_DLY;
                     cnt   <= '0;
                  end else if (idx == IDX_LAST) begin
                     state     <= ST_READY;
                     init_done <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            ST_INIT_DLY: begin
               if (cnt == DLY_LAST) begin
                  cnt <= '0;
                  if (idx == IDX_LAST) begin
                     state     <= ST_READY;
                     init_done <= 1'b1;
                  end else begin
                     state <= ST_INIT;
                     idx   <= idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_READY: state <= ST_READY;
            default: begin
               state <= ST_RST_LO;
               cnt   <= '0;
               csx   <= 1'b1;
               resx  <= 1'b0;
            end
         endcase
      end
   end

   vma412_bus_writer #(
      .WR_LOW_CYC (WR_LOW_CYC),
      .WR_HIGH_CYC(WR_HIGH_CYC)
   ) u_writer (
      .clk  (CLOCK_50),
      .rst_n(KEY0),
      .start(wr_start),
      .dc   (wr_dc),
      .data (wr_data),
      .avail(wr_avail),
      .done (wr_done),
      .idle (wr_idle),
      .wrx  (wrx),
      .dcx  (dcx),
      .lcd_d(lcd_d)
   );

endmodule

// File: tb/tb_vma412_sequencer.sv
// Directed bench for vma412_sequencer with short timing parameters.
module tb_vma412_sequencer;

   logic       CLOCK_50 = 1'b0;
   logic       KEY0 = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_dc = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready, init_done, busy, csx, resx, dcx, wrx, rdx;
   logic [7:0] lcd_d;

   always #10 CLOCK_50 = ~CLOCK_50;

   vma412_sequencer #(
      .RST_LOW_CYC (4),
      .RST_WAIT_CYC(10),
      .DLY_CYC     (8),
      .WR_LOW_CYC  (2),
      .WR_HIGH_CYC (2)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .KEY0     (KEY0),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_dc   (cmd_dc),
      .cmd_data (cmd_data),
      .init_done(init_done),
      .busy     (busy),
      .csx      (csx),
      .resx     (resx),
      .dcx      (dcx),
      .wrx      (wrx),
      .rdx      (rdx),
      .lcd_d    (lcd_d)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Cycle counter and wrx rising-edge capture (sampled on the falling edge).
   int cyc  = 0;
   int rel0 = 0;
   logic [8:0] got_q[$];
   int         got_t[$];
   logic       wrx_q = 1'b1;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   always @(negedge CLOCK_50) begin
      if (KEY0 && wrx === 1'b1 && wrx_q === 1'b0) begin
         got_q.push_back({dcx, lcd_d});
         got_t.push_back(cyc - rel0);
      end
      wrx_q <= wrx;
   end

   typedef struct {
      logic       in_dc;
      logic [7:0] in_data;
      logic [8:0] exp_byte;
      int         exp_rise;
   } vec_t;

   vec_t vec[10];

   task automatic tick();
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic release_reset();
      @(negedge CLOCK_50);
      #2 KEY0 = 1'b1;
      rel0 = cyc;
      got_q.delete();
      got_t.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_csx"},       32'(csx),       32'd1);
      check({tag, "_resx"},      32'(resx),      32'd0);
      check({tag, "_dcx"},       32'(dcx),       32'd1);
      check({tag, "_wrx"},       32'(wrx),       32'd1);
      check({tag, "_rdx"},       32'(rdx),       32'd1);
      check({tag, "_lcd_d"},     32'(lcd_d),     32'h00);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      check({tag, "_init_done"}, 32'(init_done), 32'd0);
      check({tag, "_busy"},      32'(busy),      32'd1);
   endtask

   // resx low for 4 counted cycles, csx high for 10 more, then first byte 0x01 as a command.
   task automatic check_power_up(input logic preload);
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (preload && k == 6) begin
            cmd_valid = 1'b1;
            cmd_dc    = vec[7].in_dc;
            cmd_data  = vec[7].in_data;
         end
         check($sformatf("pu_resx_k%0d", k), 32'(resx), (k >= 4) ? 32'd1 : 32'd0);
         check($sformatf("pu_csx_k%0d", k),  32'(csx),  (k < 14) ? 32'd1 : 32'd0);
         check($sformatf("pu_ready_k%0d", k), 32'(cmd_ready), 32'd0);
      end
      check("first_byte_wrx",  32'(wrx),   32'd0);
      check("first_byte_data", 32'(lcd_d), 32'h01);
      check("first_byte_dcx",  32'(dcx),   32'd0);
      check("first_byte_busy", 32'(busy),  32'd1);
   endtask

   task automatic wait_init_done();
      int early = 0;
      int t_done = -1;
      for (int n = 0; n < 200; n++) begin
         tick();
         if (init_done) begin
            t_done = cyc - rel0;
            break;
         end
         if (cmd_ready) early++;
      end
      check("init_done_timeout", 32'(t_done >= 0), 32'd1);
      check("ready_before_init_done", 32'(early), 32'd0);
      check("init_done_cycle", 32'(t_done), 32'd65);
      check("ready_first_ready_cycle", 32'(cmd_ready), 32'd1);
   endtask

   task automatic compare_captures(input int n);
      check("capture_count", 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         check($sformatf("byte_%0d", i), 32'(got_q[i]), 32'(vec[i].exp_byte));
         check($sformatf("rise_%0d", i), 32'(got_t[i]), 32'(vec[i].exp_rise));
      end
   endtask

   task automatic wait_accept(input string name);
      int ok = 0;
      for (int n = 0; n < 20; n++) begin
         if (cmd_ready) begin
            tick();
            ok = 1;
            break;
         end
         tick();
      end
      check({name, "_accept"}, 32'(ok), 32'd1);
   endtask

   initial begin
      // Init rises: first strobe 17 cycles after release, 5-cycle step per entry
      // through the writer, plus 8 cycles after each dly entry. Host writes 4 apart.
      vec[0] = '{1'b0, 8'h00, {1'b0, 8'h01}, 17};
      vec[1] = '{1'b0, 8'h00, {1'b0, 8'h11}, 30};
      vec[2] = '{1'b0, 8'h00, {1'b0, 8'h3A}, 43};
      vec[3] = '{1'b0, 8'h00, {1'b1, 8'h55}, 48};
      vec[4] = '{1'b0, 8'h00, {1'b0, 8'h36}, 53};
      vec[5] = '{1'b0, 8'h00, {1'b1, 8'h48}, 58};
      vec[6] = '{1'b0, 8'h00, {1'b0, 8'h29}, 63};
      vec[7] = '{1'b0, 8'h2C, {1'b0, 8'h2C}, 68};
      vec[8] = '{1'b1, 8'hAA, {1'b1, 8'hAA}, 72};
      vec[9] = '{1'b1, 8'h55, {1'b1, 8'h55}, 76};

      @(negedge CLOCK_50);
      check_reset_values("por");
      release_reset();

      // Host byte held pending from RST_WAIT; accepted only once READY.
      check_power_up(1'b1);
      wait_init_done();
      tick();
      check("host_latency_wrx",  32'(wrx),   32'd0);
      check("host_latency_data", 32'(lcd_d), 32'h2C);
      check("host_latency_dcx",  32'(dcx),   32'd0);
      for (int i = 8; i <= 9; i++) begin
         cmd_dc   = vec[i].in_dc;
         cmd_data = vec[i].in_data;
         wait_accept($sformatf("stream_%0d", i));
      end
      cmd_valid = 1'b0;
      repeat (6) tick();
      compare_captures(10);
      check("idle_wrx",  32'(wrx),   32'd1);
      check("idle_data", 32'(lcd_d), 32'h55);
      check("idle_dcx",  32'(dcx),   32'd1);
      check("idle_busy", 32'(busy),  32'd0);

      // Data changed right after acceptance must not reach the bus.
      cmd_valid = 1'b1;
      cmd_dc    = 1'b1;
      cmd_data  = 8'h12;
      wait_accept("hold");
      cmd_valid = 1'b0;
      cmd_dc    = 1'b0;
      cmd_data  = 8'h34;
      begin
         int seen = 0;
         for (int n = 0; n < 10; n++) begin
            if (wrx) begin
               seen = 1;
               break;
            end
            check($sformatf("hold_data_%0d", n), 32'(lcd_d), 32'h12);
            check($sformatf("hold_dcx_%0d", n),  32'(dcx),   32'd1);
            tick();
         end
         check("hold_wrx_rise", 32'(seen), 32'd1);
      end
      tick();
      check("hold_capture", (got_q.size() > 0) ? 32'(got_q[$]) : 32'h1FF, 32'h112);

      // Reset pulse in the wrx-low phase of a host write.
      cmd_valid = 1'b1;
      cmd_dc    = 1'b1;
      cmd_data  = 8'h77;
      wait_accept("abort");
      cmd_valid = 1'b0;
      check("abort_wrx_low", 32'(wrx), 32'd0);
      #2 KEY0 = 1'b0;
      #1 check_reset_values("abort");
      tick();
      check_reset_values("abort_held");
      release_reset();
      check_power_up(1'b0);
      wait_init_done();
      repeat (4) tick();
      compare_captures(7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vma412_sequencer.md
VMA412_SEQUENCER -- requirements
Module: vma412_sequencer

Interface
REQ-001 SHALL have parameter RST_LOW_CYC, default 500, giving the number of cycles resx is held low (10 us at 50 MHz).
REQ-002 SHALL have parameter RST_WAIT_CYC, default 6_000_000, giving the number of cycles waited after resx rises (120 ms).
REQ-003 SHALL have parameter DLY_CYC, default 6_000_000, giving the post-entry delay applied to flagged init entries.
REQ-004 SHALL have parameter WR_LOW_CYC, default 2, giving the number of cycles wrx is low per byte.
REQ-005 SHALL have parameter WR_HIGH_CYC, default 2, giving the number of cycles wrx is high per byte.
REQ-006 SHALL have one clock and an asynchronous active-low reset: CLOCK_50 input 1 is the system clock; KEY0 input 1 is the active-low reset.
REQ-007 SHALL have the host-side ports: cmd_valid input 1 (host byte pending); cmd_ready output 1 (byte accepted this cycle when cmd_valid is also high); cmd_dc input 1 (0=command, 1=data); cmd_data input 8 (byte value).
REQ-008 SHALL have the status ports: init_done output 1 (init list complete); busy output 1 (not in READY, or a write is in flight).
REQ-009 SHALL have the panel-side ports: csx output 1 (chip select, active-low); resx output 1 (panel reset, active-low); dcx output 1 (data/command select); wrx output 1 (write strobe, rising-edge latch); rdx output 1 (read strobe, tied high); lcd_d output 8 (parallel data bus).

Function
REQ-010 SHALL run top FSM states RST_LO -> RST_WAIT -> INIT -> (INIT_DLY) -> READY; READY is terminal until reset.
REQ-011 RST_LO SHALL drive resx=0 for exactly RST_LOW_CYC cycles, then enter RST_WAIT with resx=1.
REQ-012 RST_WAIT SHALL hold for exactly RST_WAIT_CYC cycles, then enter INIT with init index 0.
REQ-013 csx SHALL be 1 in RST_LO and RST_WAIT, and 0 from INIT onward.
REQ-014 INIT SHALL issue each init ROM entry {dly, dc, byte} (10 bits) in index order through the byte writer.
REQ-015 When an entry with dly=1 finishes writing, the FSM SHALL enter INIT_DLY for DLY_CYC cycles before issuing the next entry.
REQ-016 After the last entry (index INIT_LEN-1) and any delay it carries, the FSM SHALL enter READY and set init_done=1, sticky until reset.
REQ-017 Byte write SHALL set dcx and lcd_d in the first wrx-low cycle, hold wrx=0 for WR_LOW_CYC cycles, then wrx=1 for WR_HIGH_CYC cycles, keeping dcx and lcd_d stable throughout.
REQ-018 cmd_ready SHALL be 1 only in READY, and only while the writer is idle or in its final wrx-high cycle; this gives a back-to-back period of WR_LOW_CYC+WR_HIGH_CYC cycles.
REQ-019 An accepted byte SHALL appear on lcd_d/dcx with wrx=0 in the cycle after the handshake, giving 1-cycle latency.
REQ-020 cmd_valid before READY SHALL be ignored with cmd_ready=0; no host byte is dropped silently, because the host holds the byte until accepted.
REQ-021 Changes to cmd_data or cmd_dc after acceptance SHALL NOT affect the in-flight write.
REQ-022 rdx SHALL be constant 1 at all times.
REQ-023 Between writes, dcx and lcd_d SHALL hold their last values and wrx SHALL be 1.
REQ-024 Counters SHALL be wide enough for max(RST_WAIT_CYC, DLY_CYC), with no wrap before the terminal count.

Reset
REQ-025 While KEY0=0, outputs SHALL take these values immediately (asynchronously): csx=1, resx=0, dcx=1, wrx=1, rdx=1, lcd_d=0, cmd_ready=0, init_done=0, busy=1.
REQ-026 A reset asserted mid-write or mid-init SHALL abort the operation; after release the sequence SHALL restart at RST_LO with index 0.
REQ-027 Reset release SHALL be taken synchronously; the first RST_LO count cycle is the first rising edge with KEY0=1.

Structure
REQ-028 Package vma412_pkg SHALL hold the FSM state encoding, INIT_LEN, and the init ROM contents (ILI9341 list: SWRESET dly, SLPOUT dly, COLMOD 0x55, MADCTL, DISPON).
REQ-029 The byte strobe SHALL be implemented in sub-module vma412_bus_writer (start/done handshake; states IDLE, LOW, HIGH), shared by INIT and READY.

Verification (simulation parameters: RST_LOW_CYC=4, RST_WAIT_CYC=10, DLY_CYC=8, WR_LOW_CYC=2, WR_HIGH_CYC=2)
REQ-030 Reset release -> resx=0 for 4 cycles, then resx=1 and csx=1 for 10 cycles, then csx=0 and the first init byte 0x01 appears with dcx=0.
REQ-031 Full init -> each ROM byte is latched on a wrx rising edge in order, there is a gap of 8 cycles after each dly entry, and init_done=1 after the last byte.
REQ-032 Host streams 0x2C(dc=0), 0xAA, 0x55 with cmd_valid held high -> the three wrx rising edges are 4 cycles apart with the correct dcx and lcd_d on each.
REQ-033 cmd_valid=1 during RST_WAIT -> cmd_ready stays 0, and the byte is accepted only in the first READY cycle.
REQ-034 KEY0 pulsed low during the wrx-low phase of a host write -> outputs take their reset values in the same cycle, and the sequence restarts from REQ-030.
REQ-035 cmd_data changed from 0x12 to 0x34 in the cycle after acceptance -> lcd_d stays 0x12 until the wrx rising edge.
